// File: rtl/adc_burst_scheduler.sv
// ADC burst scheduler: frame/tick timing, ultrasonic burst drive,
// per-tick SPI acquisition of NUM_ADC masters and FIFO drain.
module adc_burst_scheduler #(
  parameter int NUM_ADC     = 5,
  parameter int SAMPLE_DIV  = 128,
  parameter int FRAME_LEN   = 588800,
  parameter int BURST_LEN   = 32,
  parameter int TX_DIV_BITS = 10
) (
  input  logic                   SYS_CLK,
  input  logic                   RSTbar,
  input  logic                   ON,
  input  logic [1:0]             CHAN_SEL,
  input  logic [NUM_ADC-1:0]     ADC_FIN,
  input  logic [16*NUM_ADC-1:0]  ADC_DATA,
  input  logic                   FIFO_FULL,
  output logic [NUM_ADC-1:0]     ADC_ENA,
  output logic [15:0]            ADC_CMD,
  output logic                   TX_PULSE,
  output logic                   FRAME_START,
  output logic                   FIFO_WR,
  output logic [15:0]            FIFO_DIN,
  output logic [2:0]             FIFO_TAG,
  output logic                   OVERRUN,
  output logic                   TIMEOUT,
  output logic                   MISSED
);

  localparam int FW = $clog2(FRAME_LEN);
  localparam int TW = $clog2(SAMPLE_DIV);
  // to_q holds cycles elapsed since the tick, so the flag lands at tick+SAMPLE_DIV-2
  localparam logic [TW-1:0] TO_LAST = TW'(SAMPLE_DIV - 3);

  typedef enum logic [1:0] {IDLE, ACQ, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [FW-1:0]          frame_q;
  logic [TX_DIV_BITS-1:0] txc_q;
  logic                   tx_q, fs_q;
  logic [NUM_ADC-1:0]     ena_q, ena_d;
  logic [NUM_ADC-1:0]     pend_q, pend_d;
  logic [NUM_ADC-1:0]     cap_we;
  logic [15:0]            cmd_q, cmd_d;
  logic [TW-1:0]          to_q, to_d;
  logic                   ovr_q, ovr_d;
  logic                   tmo_q, tmo_d;
  logic                   mis_q, mis_d;
  logic [15:0]            cap_q [NUM_ADC];
  logic                   tick, to_hit;
  logic [2:0]             sel;

  assign tick   = ON && ((frame_q % FW'(SAMPLE_DIV)) == '0);
  assign to_hit = (to_q == TO_LAST);

  always_comb begin
    sel = '0;
    for (int i = NUM_ADC - 1; i >= 0; i--)
      if (pend_q[i]) sel = 3'(i);
  end

  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar)  state_q <= IDLE;
    else if (!ON) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (tick && !FIFO_FULL) state_d = ACQ;
      ACQ:   if (ena_q == '0 || to_hit) state_d = DRAIN;
      DRAIN: if (pend_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ena_d    = ena_q;
    pend_d   = pend_q;
    cmd_d    = cmd_q;
    to_d     = to_q;
    ovr_d    = ovr_q;
    tmo_d    = tmo_q;
    mis_d    = mis_q;
    cap_we   = '0;
    FIFO_WR  = 1'b0;
    FIFO_DIN = '0;
    FIFO_TAG = '0;
    unique case (state_q)
      IDLE: begin
        if (tick && FIFO_FULL) begin
          mis_d = 1'b1;
        end else if (tick) begin
          cmd_d = {4'b0001, 1'b1, 2'b00, CHAN_SEL, 7'b1000000};
          ena_d = '1;
          to_d  = TW'(1);
        end
      end
      ACQ: begin
        to_d = to_q + TW'(1);
        if (tick) mis_d = 1'b1;
        cap_we = ADC_FIN & ena_q;
        if ((cap_we & pend_q) != '0) ovr_d = 1'b1;
        pend_d = pend_q | cap_we;
        ena_d  = ena_q & ~cap_we;
        if (to_hit) begin
          ena_d = '0;
          if ((ena_q & ~ADC_FIN) != '0) tmo_d = 1'b1;
        end
      end
      DRAIN: begin
        if (tick) mis_d = 1'b1;
        if (!FIFO_FULL && pend_q != '0) begin
          FIFO_WR     = 1'b1;
          FIFO_DIN    = cap_q[sel];
          FIFO_TAG    = sel;
          pend_d[sel] = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      frame_q <= '0;
      txc_q   <= '0;
      tx_q    <= 1'b0;
      fs_q    <= 1'b0;
      ena_q   <= '0;
      pend_q  <= '0;
      cmd_q   <= '0;
      to_q    <= '0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
      mis_q   <= 1'b0;
      for (int i = 0; i < NUM_ADC; i++) cap_q[i] <= '0;
    end else if (!ON) begin
      frame_q <= '0;
      txc_q   <= '0;
      tx_q    <= 1'b0;
      fs_q    <= 1'b0;
      ena_q   <= '0;
      pend_q  <= '0;
      cmd_q   <= '0;
      to_q    <= '0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
      mis_q   <= 1'b0;
      for (int i = 0; i < NUM_ADC; i++) cap_q[i] <= '0;
    end else begin
      frame_q <= (frame_q == FW'(FRAME_LEN - 1)) ? '0 : frame_q + FW'(1);
      txc_q   <= txc_q + TX_DIV_BITS'(1);
      tx_q    <= txc_q[TX_DIV_BITS-1] && (frame_q < FW'(BURST_LEN));
      fs_q    <= (frame_q == '0);
      ena_q   <= ena_d;
      pend_q  <= pend_d;
      cmd_q   <= cmd_d;
      to_q    <= to_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
      mis_q   <= mis_d;
      for (int i = 0; i < NUM_ADC; i++)
        if (cap_we[i]) cap_q[i] <= ADC_DATA[16*i +: 16];
    end
  end

  assign ADC_ENA     = ena_q;
  assign ADC_CMD     = cmd_q;
  assign TX_PULSE    = tx_q;
  assign FRAME_START = fs_q;
  assign OVERRUN     = ovr_q;
  assign TIMEOUT     = tmo_q;
  assign MISSED      = mis_q;

endmodule

// File: tb/tb_adc_burst_scheduler.sv
// Scoreboard bench for adc_burst_scheduler: directed samples,
// backpressure, timeout, full-at-tick, frame/TX timing, async reset.
`timescale 1ns/1ps
module tb_adc_burst_scheduler;
  localparam int N = 5;

  logic            clk = 1'b0;
  logic            rst_n, on, full;
  logic [1:0]      chan;
  logic [N-1:0]    fin;
  logic [16*N-1:0] data;
  logic [N-1:0]    ena;
  logic [15:0]     cmd, din;
  logic            tx, fs, wr, ovr, tmo, mis;
  logic [2:0]      tag;

  int n_vec = 0;
  int n_bad = 0;
  int fr = 0;
  logic [18:0] exp_q [$];

  always #5 clk = ~clk;

  adc_burst_scheduler #(
    .NUM_ADC(N), .SAMPLE_DIV(128), .FRAME_LEN(2048),
    .BURST_LEN(1024), .TX_DIV_BITS(10)
  ) dut (
    .SYS_CLK(clk), .RSTbar(rst_n), .ON(on), .CHAN_SEL(chan),
    .ADC_FIN(fin), .ADC_DATA(data), .FIFO_FULL(full),
    .ADC_ENA(ena), .ADC_CMD(cmd), .TX_PULSE(tx),
    .FRAME_START(fs), .FIFO_WR(wr), .FIFO_DIN(din),
    .FIFO_TAG(tag), .OVERRUN(ovr), .TIMEOUT(tmo), .MISSED(mis)
  );

  // time reference: position inside the frame for the current cycle
  always @(posedge clk or negedge rst_n)
    if (!rst_n)   fr <= 0;
    else if (!on) fr <= 0;
    else          fr <= (fr == 2047) ? 0 : fr + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_fr(input int v);
    int k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (fr != v && k < 5000);
    if (fr != v) chk("wait_fr", fr, v);
  endtask

  task automatic do_fin(input logic [N-1:0] m, input logic [15:0] base,
                        input bit push);
    fin = m;
    for (int i = 0; i < N; i++)
      if (m[i]) begin
        data[16*i +: 16] = base + 16'(i);
        if (push) exp_q.push_back({3'(i), base + 16'(i)});
      end
  endtask

  always @(negedge clk) begin : mon
    logic [18:0] e;
    if (rst_n) begin
      if (full) chk("wr_while_full", {31'd0, wr}, 0);
      if (wr) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_wr: got tag %0d din %h want none",
                   tag, din);
        end else begin
          e = exp_q.pop_front();
          chk("fifo_word", {13'd0, tag, din}, {13'd0, e});
        end
      end
    end
  end

  initial begin
    rst_n = 0; on = 1; chan = 2; fin = '1; data = '1; full = 1;
    #3;
    chk("rst_ena_cmd", {11'd0, ena, cmd}, 0);
    chk("rst_misc", {7'd0, tx, fs, wr, din, tag, ovr, tmo, mis}, 0);
    on = 0; fin = '0; data = '0; full = 0;
    @(posedge clk); #3; rst_n = 1;
    @(posedge clk); #1; on = 1;

    // nominal sample, FINs at 20..24 after the tick
    wait_fr(1);
    chk("nom_ena", ena, 5'h1F);
    chk("nom_cmd", cmd, 16'h1940);
    chk("nom_fs", fs, 1);
    wait_fr(2);
    chk("fs_pulse_end", fs, 0);
    for (int i = 0; i < N; i++) begin
      wait_fr(20 + i);
      do_fin(N'(1) << i, 16'hA000, 1);
    end
    wait_fr(25); fin = '0;
    wait_fr(40);
    chk("nom_flags", {ovr, tmo, mis}, 0);
    wait_fr(120);
    chk("nom_drained", exp_q.size(), 0);
    chk("nom_ena_idle", ena, 0);

    // backpressure on DRAIN cycles 2-4, simultaneous FINs 1+2 and 3+4
    wait_fr(148); do_fin(5'h01, 16'hB000, 1);
    wait_fr(149); do_fin(5'h06, 16'hB000, 1);
    wait_fr(150); do_fin(5'h18, 16'hB000, 1);
    wait_fr(151); fin = '0;
    wait_fr(153); full = 1;
    wait_fr(156); full = 0;
    wait_fr(200);
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_missed", mis, 0);

    // ADC 3 never finishes
    wait_fr(266); do_fin(5'h17, 16'hC000, 1);
    wait_fr(267); fin = '0;
    wait_fr(381);
    chk("to_before", tmo, 0);
    chk("to_ena_wait", ena, 5'h08);
    wait_fr(382);
    chk("to_flag", tmo, 1);
    chk("to_ena_clr", ena, 0);
    wait_fr(390);
    chk("tick_in_drain", mis, 1);
    chk("to_drained", exp_q.size(), 0);

    // ON low clears, then FIFO full at the tick
    wait_fr(400); on = 0;
    @(posedge clk); #1;
    chk("on_clr_flags", {ovr, tmo, mis}, 0);
    chk("on_clr_ena", ena, 0);
    full = 1; on = 1;
    wait_fr(1);
    chk("full_tick_mis", mis, 1);
    chk("full_tick_ena", ena, 0);
    full = 0;
    wait_fr(129);
    chk("next_tick_ena", ena, 5'h1F);
    wait_fr(140); do_fin(5'h1F, 16'hD000, 1);
    wait_fr(141); fin = '0;
    wait_fr(200);
    chk("full_drained", exp_q.size(), 0);

    // frame start and transmitter burst
    wait_fr(511);  chk("tx_511", tx, 0);
    wait_fr(513);  chk("tx_513", tx, 1);
    wait_fr(1024); chk("tx_1024", tx, 1);
    wait_fr(1025); chk("tx_1025", tx, 0);
    wait_fr(2047); chk("fs_2047", fs, 0);
    wait_fr(1);    chk("fs_wrap", fs, 1);
    wait_fr(513);  chk("tx_f2_513", tx, 1);
    wait_fr(1100); chk("tx_f2_1100", tx, 0);

    // async reset mid-DRAIN with data pending
    wait_fr(133); do_fin(5'h1F, 16'hE000, 0);
    wait_fr(134); fin = '0; full = 1;
    wait_fr(137); #2;
    rst_n = 0; #1;
    chk("arst_ena_cmd", {11'd0, ena, cmd}, 0);
    chk("arst_misc", {7'd0, tx, fs, wr, din, tag, ovr, tmo, mis}, 0);
    repeat (2) @(posedge clk);
    full = 0; #3; rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_wr", {31'd0, wr}, 0);
    end
    repeat (20) @(posedge clk);
    chk("final_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
